// File: rtl/ads868x_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ads868x_pkg
// Description : Shared definitions for the ADS868x sample stream. Field
//               offsets and widths of the 56-bit sample word, the packed
//               sample struct, and a helper that limits the averaging depth.
//               Used by the controller and by the channel averager.
// Revision    : 1.0 - initial release
// ============================================================================
package ads868x_pkg;

    // Field layout of the 56-bit sample word: {ts, ch, code}
    localparam int CODE_LSB = 0;
    localparam int CODE_W   = 16;
    localparam int CH_LSB   = 16;
    localparam int CH_W     = 8;
    localparam int TS_LSB   = 24;
    localparam int TS_W     = 32;
    localparam int SAMPLE_W = TS_W + CH_W + CODE_W;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [CH_W-1:0]   ch;
        logic [CODE_W-1:0] code;
    } ads868x_sample_t;

    // Limit a requested averaging depth to the largest supported depth.
    function automatic logic [3:0] clamp_log2n(input logic [3:0] log2n,
                                               input int         max_log2n);
        logic [3:0] w_res;
        w_res = log2n;
        if (int'(log2n) > max_log2n) begin
            w_res = 4'(max_log2n);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ads868x_avg_div.sv
`default_nettype none
// ============================================================================
// Module      : ads868x_avg_div
// Description : Combinational divide-by-2^log2n of a widened block sum,
//               with optional round-half-up and clamp to 16 bits.
// Ports       : i_sum   - widened sum of the block samples
//               i_log2n - averaging depth (already clamped by the caller)
//               o_avg   - averaged 16-bit code
// Options     : ADS868X_AVG_ROUND_EN - add 2^(log2n-1) before the shift
//               (round half up); nothing is added when log2n is 0. When
//               undefined the result is truncated (floor).
// Revision    : 1.0 - initial release
// ============================================================================
module ads868x_avg_div
    import ads868x_pkg::*;
#(
    parameter int MAX_LOG2N = 8,
    parameter int SUM_W     = CODE_W + MAX_LOG2N + 1
) (
    input  logic [SUM_W-1:0]  i_sum,
    input  logic [3:0]        i_log2n,
    output logic [CODE_W-1:0] o_avg
);

    logic [SUM_W-1:0] w_rnd;
    logic [SUM_W-1:0] w_biased;
    logic [SUM_W-1:0] w_shifted;

    always_comb begin
        w_rnd = '0;
`ifdef ADS868X_AVG_ROUND_EN
        if (i_log2n != 4'd0) begin
            w_rnd = {{(SUM_W-1){1'b0}}, 1'b1} << (i_log2n - 4'd1);
        end
`endif
        // The sum carries one spare bit, so the rounding bias cannot wrap.
        w_biased  = i_sum + w_rnd;
        w_shifted = w_biased >> i_log2n;
        if (|w_shifted[SUM_W-1:CODE_W]) begin
            o_avg = {CODE_W{1'b1}};
        end else begin
            o_avg = w_shifted[CODE_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ads868x_chan_avg.sv
`default_nettype none
// ============================================================================
// Module      : ads868x_chan_avg
// Description : Per-channel boxcar averager on the ADS868x 56-bit sample
//               stream. Accumulates 2^cfg_log2n samples per channel and
//               emits one averaged word {ts0, ch, avg} per block, keeping
//               the input word format. AXI-Stream in and out.
// Ports       : aclk, aresetn        - clock, async active-low reset
//               s_axis_*             - input sample stream
//               m_axis_*             - averaged output stream
//               cfg_log2n            - averaging depth (clamped to MAX_LOG2N)
//               ctrl_clear           - pulse, discards partial blocks
//               stat_bad_ch          - saturating count of dropped beats
//                                      with channel index >= NUM_CH
// Options     : ADS868X_AVG_ROUND_EN - round half up instead of floor
//               (implemented in ads868x_avg_div)
// Revision    : 1.0 - initial release
// ============================================================================
module ads868x_chan_avg
    import ads868x_pkg::*;
#(
    parameter int NUM_CH    = 16,
    parameter int MAX_LOG2N = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [SAMPLE_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic [3:0]          cfg_log2n,
    input  logic                ctrl_clear,
    output logic [15:0]         stat_bad_ch
);

    localparam int ACC_W = CODE_W + MAX_LOG2N;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = MAX_LOG2N;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc [NUM_CH];
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [TS_W-1:0]  r_ts0 [NUM_CH];

    logic [3:0]          r_log2n_q;
    logic                r_mvalid;
    logic [SAMPLE_W-1:0] r_mdata;
    logic [15:0]         r_bad_cnt;

    ads868x_sample_t     w_in;
    logic [3:0]          w_log2n;
    logic                w_clr;
    logic                w_accept;
    logic                w_ch_ok;
    logic                w_take;
    logic [IDX_W-1:0]    w_idx;
    logic [CNT_W:0]      w_lim_full;
    logic [CNT_W-1:0]    w_lim;
    logic [CNT_W-1:0]    w_cnt_eff;
    logic                w_first;
    logic                w_last;
    logic [ACC_W-1:0]    w_acc_eff;
    logic [SUM_W-1:0]    w_sum;
    logic [TS_W-1:0]     w_ts0;
    logic [CODE_W-1:0]   w_avg;

    // ------------------------------------------------------------------
    // Input decode and block bookkeeping
    // ------------------------------------------------------------------
    assign w_in          = ads868x_sample_t'(s_axis_tdata);
    assign w_log2n       = clamp_log2n(cfg_log2n, MAX_LOG2N);
    assign s_axis_tready = !r_mvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_ch_ok       = ({1'b0, w_in.ch} < (CH_W + 1)'(NUM_CH));
    assign w_take        = w_accept && w_ch_ok;
    assign w_idx         = w_in.ch[IDX_W-1:0];

    // A clear pulse or a depth change restarts every block; the depth
    // compare is against the value seen on the previous cycle.
    assign w_clr = ctrl_clear || (w_log2n != r_log2n_q);

    // Last count value of a block: 2^log2n - 1
    assign w_lim_full = ({{CNT_W{1'b0}}, 1'b1} << w_log2n) - {{CNT_W{1'b0}}, 1'b1};
    assign w_lim      = w_lim_full[CNT_W-1:0];

    // A beat arriving while a clear is in effect starts a fresh block, so
    // its view of the channel count is forced to zero. State is read
    // straight from the flops each cycle, so back-to-back beats on one
    // channel see the value written on the previous edge.
    always_comb begin
        w_cnt_eff = w_clr ? '0 : r_cnt[w_idx];
        w_first   = (w_cnt_eff == '0);
        w_last    = (w_cnt_eff == w_lim);
        w_acc_eff = w_first ? '0 : r_acc[w_idx];
        w_ts0     = w_first ? w_in.ts : r_ts0[w_idx];
        w_sum     = {1'b0, w_acc_eff} + SUM_W'(w_in.code);
    end

    ads868x_avg_div #(
        .MAX_LOG2N (MAX_LOG2N),
        .SUM_W     (SUM_W)
    ) u_div (
        .i_sum   (w_sum),
        .i_log2n (w_log2n),
        .o_avg   (w_avg)
    );

    // ------------------------------------------------------------------
    // Channel accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
                r_ts0[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_clr) begin
                    r_cnt[i] <= '0;
                end
                if (w_take && (w_idx == IDX_W'(i))) begin
                    r_cnt[i] <= w_last ? '0 : (w_cnt_eff + CNT_W'(1));
                    r_acc[i] <= w_sum[ACC_W-1:0];
                    if (w_first) begin
                        r_ts0[i] <= w_in.ts;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_log2n_q <= 4'd0;
        end else begin
            r_log2n_q <= w_log2n;
        end
    end

    // ------------------------------------------------------------------
    // Output register. A completing beat is only accepted when the
    // register is empty or draining, so loading here never loses a word.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
        end else begin
            if (w_take && w_last) begin
                r_mvalid <= 1'b1;
                r_mdata  <= {w_ts0, w_in.ch, w_avg};
            end else if (m_axis_tready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tdata  = r_mdata;

    // ------------------------------------------------------------------
    // Out-of-range channel statistics
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bad_cnt <= 16'd0;
        end else if (w_accept && !w_ch_ok && (r_bad_cnt != 16'hFFFF)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign stat_bad_ch = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ads868x_chan_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ads868x_chan_avg
// Description : Directed testbench for ads868x_chan_avg. Expected output
//               words are queued as stimulus is issued; a monitor pops and
//               compares every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ads868x_chan_avg;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [55:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [55:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [3:0]  cfg_log2n;
    logic        ctrl_clear;
    logic [15:0] stat_bad_ch;

    int          checks   = 0;
    int          failures = 0;
    logic [55:0] exp_q[$];
    logic [55:0] mon_exp;

    always #5 aclk = ~aclk;

    ads868x_chan_avg #(
        .NUM_CH    (16),
        .MAX_LOG2N (8)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .cfg_log2n     (cfg_log2n),
        .ctrl_clear    (ctrl_clear),
        .stat_bad_ch   (stat_bad_ch)
    );

    function automatic logic [55:0] mk(input logic [31:0] ts, input logic [7:0] ch,
                                       input logic [15:0] code);
        return {ts, ch, code};
    endfunction

    // Scoreboard monitor: a beat transfers at the next rising edge when
    // valid and ready are both high at the falling edge.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got=%h want=none", m_tdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_tdata !== mon_exp) begin
                    failures++;
                    $display("FAIL out_word got=%h want=%h", m_tdata, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [55:0] got, input logic [55:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] ch, input logic [15:0] code, input logic [31:0] ts);
        logic rdy;
        int   n;
        s_tdata  = {ts, ch, code};
        s_tvalid = 1'b1;
        n        = 0;
        do begin
            @(negedge aclk);
            rdy = s_tready;
            @(posedge aclk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=ready_low want=accepted");
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] v);
        cfg_log2n = v;
        idle(2);
    endtask

    // Directed vectors: {ch, code, ts} for passthrough
    logic [55:0] pt_vec [4];

    logic [15:0] e_avg4;
    logic [15:0] e_avg2;
    int          n_wait;

    initial begin
        aresetn    = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b1;
        cfg_log2n  = 4'd0;
        ctrl_clear = 1'b0;
`ifdef ADS868X_AVG_ROUND_EN
        e_avg4 = 16'd12;  // (46+2)>>2
        e_avg2 = 16'd4;   // (7+1)>>1
`else
        e_avg4 = 16'd11;  // 46>>2
        e_avg2 = 16'd3;   // 7>>1
`endif
        pt_vec[0] = mk(32'd7,          8'd5,  16'h1234);
        pt_vec[1] = mk(32'd8,          8'd0,  16'h0000);
        pt_vec[2] = mk(32'hFFFF_FFFF,  8'd15, 16'hFFFF);
        pt_vec[3] = mk(32'h0001_0000,  8'd9,  16'h8001);

        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_m_tvalid", 56'(m_tvalid), 56'd0);
        chk("rst_m_tdata",  m_tdata,       56'd0);
        chk("rst_stat",     56'(stat_bad_ch), 56'd0);
        chk("rst_s_tready", 56'(s_tready), 56'd1);
        @(posedge aclk);
        #1;

        // Out-of-range channels are dropped and counted
        set_cfg(4'd0);
        send(8'd16,  16'h1111, 32'd1);
        send(8'd200, 16'h2222, 32'd2);
        idle(3);
        chk("bad_ch_count", 56'(stat_bad_ch), 56'd2);

        // Depth 4, ch 3, codes 10..13
        set_cfg(4'd2);
        exp_q.push_back(mk(32'd100, 8'd3, e_avg4));
        for (int i = 0; i < 4; i++) send(8'd3, 16'(10 + i), 32'(100 + i));
        idle(3);

        // Depth 2, ch 2, codes 3,4
        set_cfg(4'd1);
        exp_q.push_back(mk(32'd20, 8'd2, e_avg2));
        send(8'd2, 16'd3, 32'd20);
        send(8'd2, 16'd4, 32'd21);
        idle(3);

        // Passthrough, back to back
        set_cfg(4'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pt_vec[i]);
            send(pt_vec[i][23:16], pt_vec[i][15:0], pt_vec[i][55:24]);
        end
        idle(3);

        // Backpressure: one word pending, next beat must stall
        m_tready = 1'b0;
        exp_q.push_back(mk(32'd1000, 8'd4, 16'hBEEF));
        send(8'd4, 16'hBEEF, 32'd1000);
        s_tdata  = mk(32'd1001, 8'd6, 16'h0BAD);
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_s_tready", 56'(s_tready), 56'd0);
            chk("bp_m_tvalid", 56'(m_tvalid), 56'd1);
            chk("bp_m_tdata",  m_tdata, mk(32'd1000, 8'd4, 16'hBEEF));
            @(posedge aclk);
            #1;
        end
        m_tready = 1'b1;
        exp_q.push_back(mk(32'd1001, 8'd6, 16'h0BAD));
        send(8'd6, 16'h0BAD, 32'd1001);
        idle(3);

        // Depth 256, full-scale codes interleaved on ch 0 and ch 15
        set_cfg(4'd8);
        exp_q.push_back(mk(32'd0, 8'd0,  16'hFFFF));
        exp_q.push_back(mk(32'd1, 8'd15, 16'hFFFF));
        for (int i = 0; i < 512; i++) send((i % 2 == 1) ? 8'd15 : 8'd0, 16'hFFFF, 32'(i));
        idle(3);

        // Partial block discarded by ctrl_clear
        set_cfg(4'd2);
        send(8'd1, 16'd1000, 32'd50);
        send(8'd1, 16'd1000, 32'd51);
        idle(1);
        ctrl_clear = 1'b1;
        @(posedge aclk);
        #1;
        ctrl_clear = 1'b0;
        idle(1);
        exp_q.push_back(mk(32'd60, 8'd1, 16'd10));  // 40/4, no remainder
        send(8'd1, 16'd4,  32'd60);
        send(8'd1, 16'd8,  32'd61);
        send(8'd1, 16'd12, 32'd62);
        send(8'd1, 16'd16, 32'd63);
        idle(3);

        // Partial block discarded by a reset pulse
        send(8'd1, 16'd1000, 32'd70);
        send(8'd1, 16'd1000, 32'd71);
        idle(1);
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(2);
        chk("rst2_stat",     56'(stat_bad_ch), 56'd0);
        chk("rst2_m_tvalid", 56'(m_tvalid),    56'd0);
        exp_q.push_back(mk(32'd80, 8'd1, 16'd21));  // 84/4 (86/4 floors too)
        send(8'd1, 16'd20, 32'd80);
        send(8'd1, 16'd20, 32'd81);
        send(8'd1, 16'd20, 32'd82);
        send(8'd1, 16'd24, 32'd83);
        idle(5);

        n_wait = 0;
        while (exp_q.size() != 0 && n_wait < 200) begin
            @(posedge aclk);
            n_wait++;
        end
        chk("queue_drained", 56'(exp_q.size()), 56'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
